// File: rtl/rbsp_extract_buffer.sv
// RBSP extraction buffer: strips emulation-prevention bytes from NAL payload
// and packs RBSP bits into an MSB-aligned lookahead window.
// Optional build macro RBSP_EP_COUNTER_EN adds a saturating ep_count output.
module rbsp_extract_buffer #(
  parameter int BUF_BITS    = 64,
  parameter int WINDOW_BITS = 32,
  parameter int FWD_W       = 6,
  parameter int FILL_W      = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   nalu_start,
  input  logic                   nalu_done,
  input  logic [7:0]             nalu_byte,
  input  logic                   nalu_byte_valid,
  output logic                   nalu_byte_rd,
  input  logic [FWD_W-1:0]       forward_len,
  output logic [WINDOW_BITS-1:0] rbsp_out,
  output logic                   rbsp_buffer_valid,
  output logic [FILL_W-1:0]      rbsp_fill
`ifdef RBSP_EP_COUNTER_EN
  ,
  output logic [15:0]            ep_count
`endif
);

  localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(BUF_BITS - 8);
  localparam logic [FILL_W-1:0] WIN_LVL  = FILL_W'(WINDOW_BITS);
  localparam logic [FILL_W-1:0] BYTE_LEN = FILL_W'(8);

  logic [BUF_BITS-1:0] r_buf;
  logic [FILL_W-1:0]   r_fill;
  logic [1:0]          r_zero_run;

  logic [BUF_BITS-1:0] w_byte_ext;
  logic [BUF_BITS-1:0] w_buf_next;
  logic [FILL_W-1:0]   w_fwd;
  logic [FILL_W-1:0]   w_fill_after;
  logic [FILL_W-1:0]   w_fill_next;
  logic [1:0]          w_zero_run_next;
  logic                w_valid;
  logic                w_rd;
  logic                w_take;
  logic                w_is_ep;
  logic                w_append;

  assign w_byte_ext = {nalu_byte, {(BUF_BITS-8){1'b0}}};

  // Accept/strip decision, consume shift and append placement for next state
  always_comb begin
    w_valid         = (r_fill >= WIN_LVL) || (nalu_done && (r_fill != {FILL_W{1'b0}}));
    w_rd            = rst_n && ena && !nalu_start && (r_fill <= FULL_LVL);
    w_take          = w_rd && nalu_byte_valid;
    w_is_ep         = w_take && (nalu_byte == 8'h03) && (r_zero_run == 2'd2);
    w_append        = w_take && !w_is_ep;
    w_fwd           = {FILL_W{1'b0}};
    w_fill_after    = r_fill;
    w_buf_next      = r_buf;
    w_fill_next     = r_fill;
    w_zero_run_next = r_zero_run;

    if (ena && w_valid) begin
      w_fwd = FILL_W'(forward_len);
    end else begin
      w_fwd = {FILL_W{1'b0}};
    end

    w_fill_after = r_fill - w_fwd;
    w_buf_next   = r_buf << w_fwd;

    // Bits at or beyond fill are always zero, so OR-ing the new byte is safe
    if (w_append) begin
      w_buf_next  = w_buf_next | (w_byte_ext >> w_fill_after);
      w_fill_next = w_fill_after + BYTE_LEN;
    end else begin
      w_fill_next = w_fill_after;
    end

    if (w_is_ep) begin
      w_zero_run_next = 2'd0;
    end else if (w_append) begin
      if (nalu_byte == 8'h00) begin
        w_zero_run_next = (r_zero_run == 2'd2) ? 2'd2 : (r_zero_run + 2'd1);
      end else begin
        w_zero_run_next = 2'd0;
      end
    end else begin
      w_zero_run_next = r_zero_run;
    end
  end

  // Buffer, fill and zero-run state; nalu_start flushes ahead of everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf      <= {BUF_BITS{1'b0}};
      r_fill     <= {FILL_W{1'b0}};
      r_zero_run <= 2'd0;
    end else if (ena) begin
      if (nalu_start) begin
        r_buf      <= {BUF_BITS{1'b0}};
        r_fill     <= {FILL_W{1'b0}};
        r_zero_run <= 2'd0;
      end else begin
        r_buf      <= w_buf_next;
        r_fill     <= w_fill_next;
        r_zero_run <= w_zero_run_next;
      end
    end
  end

`ifdef RBSP_EP_COUNTER_EN
  logic [15:0] r_ep_count;

  // Saturating count of discarded emulation-prevention bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ep_count <= 16'd0;
    end else if (ena) begin
      if (nalu_start) begin
        r_ep_count <= 16'd0;
      end else if (w_is_ep && (r_ep_count != 16'hFFFF)) begin
        r_ep_count <= r_ep_count + 16'd1;
      end
    end
  end

  assign ep_count = r_ep_count;
`endif

  assign nalu_byte_rd      = w_rd;
  assign rbsp_buffer_valid = w_valid;
  assign rbsp_fill         = r_fill;
  assign rbsp_out          = r_buf[BUF_BITS-1 -: WINDOW_BITS];

endmodule

// File: doc/rbsp_extract_buffer.md
Name: rbsp_extract_buffer

Overview:
- Sits directly upstream of the bitstream controller, between the NAL-unit byte reader and the syntax parsers.
- Accepts raw NAL payload bytes and strips emulation-prevention bytes (0x03 after two 0x00).
- Packs the remaining RBSP bits into an MSB-aligned shift buffer and presents a fixed lookahead window.
- Drives rbsp_buffer_valid, which gates the bitstream controller and every parser enable.

Parameters:
- BUF_BITS, 64: internal shift buffer capacity in bits; multiple of 8, at least WINDOW_BITS+8.
- WINDOW_BITS, 32: width of the lookahead window presented to the bitstream controller.
- FWD_W, 6: width of forward_len; must hold WINDOW_BITS.
- FILL_W, 7: width of the fill counter; must hold BUF_BITS.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  stage enable (rbsp_buffer_ena); when low, all state is frozen.
- nalu_start  in  1  one-cycle pulse marking the first byte of a new NAL; flushes the buffer.
- nalu_done  in  1  level: upstream has delivered the last byte of the current NAL.
- nalu_byte  in  8  raw NAL payload byte.
- nalu_byte_valid  in  1  nalu_byte is valid.
- nalu_byte_rd  out  1  combinational accept; a byte is taken when nalu_byte_valid && nalu_byte_rd.
- forward_len  in  FWD_W  bits consumed by the controller this cycle (0..WINDOW_BITS).
- rbsp_out  out  WINDOW_BITS  top WINDOW_BITS of the buffer, MSB = next unread bit.
- rbsp_buffer_valid  out  1  the window is consumable.
- rbsp_fill  out  FILL_W  number of valid bits currently held.

Behaviour:
- Reset (async, rst_n=0): buffer=0, fill=0, zero_run=0, ep_count=0, rbsp_out=0, rbsp_buffer_valid=0, nalu_byte_rd=0.
- nalu_byte_rd = ena && !nalu_start && (fill <= BUF_BITS-8). The decision uses current fill only; same-cycle consumption is ignored.
- rbsp_buffer_valid = (fill >= WINDOW_BITS) || (nalu_done && fill != 0). It is derived from registers only, with no combinational path from forward_len.
- rbsp_out = buffer[BUF_BITS-1 -: WINDOW_BITS]. Bit positions at or beyond fill always read 0; the controller relies on zero padding at the end of a NAL.
- Emulation prevention on each accepted byte:
  - byte==0x03 and zero_run==2: discard the byte, zero_run<=0, ep_count+1.
  - otherwise append the byte; zero_run <= (byte==0x00) ? min(zero_run+1,2) : 0.
  - Sequence 00 00 03 03 keeps the second 03. Sequence 00 00 00 03 also discards the 03 (zero_run saturates at 2).
- Consume: when ena && rbsp_buffer_valid, shift the buffer left by forward_len, fill -= forward_len, and zero-fill from the LSB side.
  - forward_len > fill is illegal and must never be issued by the controller.
  - When valid is asserted only through nalu_done, forward_len may be up to fill.
  - forward_len is ignored when rbsp_buffer_valid=0.
- Simultaneous consume and append in one cycle:
  - New byte is placed at bit offset (fill - forward_len) below the MSB, after the shift.
  - fill_next = fill - forward_len + (appended ? 8 : 0).
- Latency: a byte accepted in cycle N appears in rbsp_out, rbsp_fill and rbsp_buffer_valid in cycle N+1. A consume in cycle N is reflected in cycle N+1.
- nalu_start has priority over everything:
  - buffer<=0, fill<=0, zero_run<=0; no append, no consume.
  - nalu_byte_rd is low that cycle, so the byte presented is held by upstream, not lost.
  - It is honoured only when ena=1.
- ena=0: no state changes, nalu_byte_rd=0. Outputs hold their values.
- Full boundary: at fill=BUF_BITS-8 a byte is still accepted; above that, nalu_byte_rd=0 until consumption brings fill back down.
- Empty boundary: at fill=0, rbsp_buffer_valid=0 even if nalu_done=1.

Optional Feature:
- Macro: RBSP_EP_COUNTER_EN.
- Defined: adds output ep_count (16 bits, saturating at 0xFFFF). It counts discarded emulation-prevention bytes, clears on reset and on nalu_start, and is used by the debug/trace monitor.
- Undefined: port and counter are absent, and emulation-prevention stripping is unchanged.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> rbsp_out=0, rbsp_fill=0, rbsp_buffer_valid=0 immediately, without waiting for a clock edge.
- Emulation removal: feed 00 00 03 01 AA BB with forward_len=0 -> rbsp_fill=40, rbsp_out=0x000001AA, nalu_byte_rd high throughout.
- Double 03: feed 00 00 03 03 11 22 -> rbsp_out=0x00000311; with the feature on, ep_count=1.
- Full/backpressure: feed 8 bytes, forward_len=0 -> fill=64, nalu_byte_rd=0. Then forward_len=8 for one cycle -> fill=56, and the next byte is accepted the following cycle.
- Simultaneous: fill=32 window 0x12345678, forward_len=5 with byte 0xFF accepted -> fill=35, rbsp_out=0x468ACF1F.
- End and flush: 16 bits left with nalu_done=1 -> valid=1, rbsp_out=0xXXXX0000 (low 16 bits zero); consume 16 -> fill=0, valid=0. Then nalu_start -> zero_run cleared, and 00 00 03 split across NALs is not stripped.
